// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared definitions for the on-chip RAM bus: state encodings,
//               default bus widths and the strobe counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_STROBE = 3'd4,
        RD_DONE   = 3'd5
    } state_e;

    // Width of a down-counter that must hold the larger of two strobe lengths.
    function automatic int strobe_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_data_io.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_io
// Description : Tristate pad for the RAM data bus. Keeps the inout isolated
//               so the bus master only sees separate in/out/enable signals.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_io #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  oe_i,
    input  logic [DATA_WIDTH-1:0] out_i,
    output logic [DATA_WIDTH-1:0] in_o,
    inout  wire  [DATA_WIDTH-1:0] data_io
);

    assign data_io = oe_i ? out_i : {DATA_WIDTH{1'bz}};
    assign in_o    = data_io;

endmodule
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Bus initiator for the on-chip RAM. Converts single-cycle core
//               requests into setup / strobe / hold / turnaround RAM cycles
//               and returns read data with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WRITE_CYCLES = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  read,
    output logic                  write
);

    localparam int CW = strobe_cnt_width(WRITE_CYCLES, READ_LATENCY);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  done_q, done_d;

    logic                  data_oe;
    logic [DATA_WIDTH-1:0] data_in;

    // The bus is driven from the setup cycle of a write through its hold cycle.
    assign data_oe = ((state_q == SETUP) && we_q) ||
                     (state_q == WR_STROBE) || (state_q == WR_HOLD);

    mem_data_io #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_io (
        .oe_i    (data_oe),
        .out_i   (wdata_q),
        .in_o    (data_in),
        .data_io (data)
    );

    // State and registered bus outputs; reset drops strobes immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            address_q <= '0;
            rdata_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            address_q <= address_d;
            rdata_q   <= rdata_d;
            read_q    <= read_d;
            write_q   <= write_d;
            done_q    <= done_d;
        end
    end

    // Next-state sequencing; strobes and done are decoded from the next state
    // so they are registered and line up exactly with the state they belong to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        address_d = address_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d      = we;
                    wdata_d   = wdata;
                    address_d = addr;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (we_q) begin
                    state_d = WR_STROBE;
                    cnt_d   = WR_LOAD;
                end else begin
                    state_d = RD_STROBE;
                    cnt_d   = RD_LOAD;
                end
            end
            WR_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: state_d = IDLE;
            RD_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = RD_DONE;
                    rdata_d = data_in;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        write_d = (state_d == WR_STROBE);
        read_d  = (state_d == RD_STROBE);
        done_d  = (state_d == WR_HOLD) || (state_d == RD_DONE);
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign address = address_q;
    assign read    = read_q;
    assign write   = write_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Scoreboard bench for mem_bus_master. Two instances (1/1 and
//               3/2 strobe cycles) share the request inputs; sel picks which
//               one sees req and which one the monitor observes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;
    logic       we    = 1'b0;
    logic       sel   = 1'b0;
    logic [9:0] addr  = '0;
    logic [7:0] wdata = '0;

    logic       ready0, done0, read0, write0;
    logic [7:0] rdata0;
    logic [9:0] address0;
    wire  [7:0] data0;
    logic       ready1, done1, read1, write1;
    logic [7:0] rdata1;
    logic [9:0] address1;
    wire  [7:0] data1;

    logic [7:0] ram0 [0:1023];
    logic [7:0] ram1 [0:1023];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_master #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .WRITE_CYCLES(1), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .req(req & ~sel), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready0), .done(done0), .rdata(rdata0), .address(address0), .data(data0),
        .read(read0), .write(write0));

    mem_bus_master #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .WRITE_CYCLES(3), .READ_LATENCY(2)) u_dut1 (
        .clk(clk), .reset(reset), .req(req & sel), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready1), .done(done1), .rdata(rdata1), .address(address1), .data(data1),
        .read(read1), .write(write1));

    // Behavioural RAMs: drive the bus while read is high, store while write is high.
    assign data0 = read0 ? ram0[address0] : 8'hzz;
    assign data1 = read1 ? ram1[address1] : 8'hzz;
    always @(posedge clk) if (write0) ram0[address0] <= data0;
    always @(posedge clk) if (write1) ram1[address1] <= data1;

    // Observed view of the selected instance.
    wire       ready_m   = sel ? ready1   : ready0;
    wire       done_m    = sel ? done1    : done0;
    wire       read_m    = sel ? read1    : read0;
    wire       write_m   = sel ? write1   : write0;
    wire [7:0] rdata_m   = sel ? rdata1   : rdata0;
    wire [9:0] address_m = sel ? address1 : address0;
    wire [7:0] data_m    = sel ? data1    : data0;
    wire       oe_m      = sel ? u_dut1.data_oe : u_dut0.data_oe;

    typedef struct {
        bit         is_wr;
        logic [7:0] rdata;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] last_rd [2];
    bit         watch_3ff = 1'b0;

    function automatic int wc_cur();
        return sel ? 3 : 1;
    endfunction
    function automatic int rl_cur();
        return sel ? 2 : 1;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint req_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // Issue one request; returns at posedge+1 right after it was accepted.
    task automatic issue(input bit w, input logic [9:0] a, input logic [7:0] d, input logic [7:0] rd_exp);
        exp_t e;
        int   n;
        e.is_wr = w;
        e.rdata = w ? last_rd[sel] : rd_exp;
        e.lat   = w ? wc_cur() + 1 : rl_cur() + 1;
        if (!w) last_rd[sel] = rd_exp;
        exp_q.push_back(e);
        we = w; addr = a; wdata = d; req = 1'b1;
        n = 0;
        while (!ready_m && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 50, "accept_timeout", n, 50);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        req = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || !ready_m) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 100, "drain_timeout", n, 100);
    endtask

    // Monitor: bus invariants, strobe widths, setup cycle and scoreboard pops.
    logic [9:0] acc_addr, prev_addr;
    logic [7:0] acc_wdata;
    bit         acc_we, setup_chk, done_prev, prev_strobe;
    int         acc_cyc, wr_run, rd_run;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            wr_run = 0; rd_run = 0; setup_chk = 0; done_prev = 0; prev_strobe = 0;
        end else begin
            check(!(read_m && write_m), "rw_exclusive", {read_m, write_m}, 0);
            check(!(oe_m && read_m), "drive_during_read", oe_m, 0);
            check(!(oe_m && ready_m), "drive_in_idle", oe_m, 0);
            if (done_m) check(!done_prev, "done_single_pulse", done_prev, 0);
            if (prev_strobe && (read_m || write_m))
                check(address_m == prev_addr, "addr_stable", address_m, prev_addr);
            if (watch_3ff) check(address_m != 10'h3FF, "busy_req_ignored", address_m, 0);
            if (setup_chk) begin
                check(address_m == acc_addr, "setup_addr", address_m, acc_addr);
                check(!read_m && !write_m, "setup_strobes", {read_m, write_m}, 0);
                check(oe_m == acc_we, "setup_oe", oe_m, acc_we);
                setup_chk = 0;
            end
            if (req && ready_m) begin
                acc_cyc = cyc + 1; acc_addr = addr; acc_we = we; acc_wdata = wdata;
                setup_chk = 1;
            end
            if (write_m) begin
                check(data_m == acc_wdata, "write_data", data_m, acc_wdata);
                wr_run++;
            end else if (wr_run > 0) begin
                check(wr_run == wc_cur(), "write_width", wr_run, wc_cur());
                wr_run = 0;
            end
            if (read_m) rd_run++;
            else if (rd_run > 0) begin
                check(rd_run == rl_cur(), "read_width", rd_run, rl_cur());
                rd_run = 0;
            end
            if (done_m) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(rdata_m == e.rdata, "rdata", rdata_m, e.rdata);
                    check(cyc - acc_cyc == e.lat, "latency", cyc - acc_cyc, e.lat);
                    if (e.is_wr) begin
                        check(oe_m && data_m == acc_wdata, "write_hold_data", data_m, acc_wdata);
                    end else begin
                        check(!oe_m && !read_m && !write_m, "turnaround", {oe_m, read_m, write_m}, 0);
                    end
                end
            end
            done_prev   = done_m;
            prev_strobe = read_m || write_m;
            prev_addr   = address_m;
        end
    end

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;

        // Reset state of both instances
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check(!read_m && !write_m && !done_m, "reset_strobes", {read_m, write_m, done_m}, 0);
            check(address_m == 10'h0, "reset_address", address_m, 0);
            check(rdata_m == 8'h00, "reset_rdata", rdata_m, 0);
            check(!oe_m, "reset_oe", oe_m, 0);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check(ready_m, "ready_after_reset", ready_m, 1);

        // Reset in the middle of a write strobe
        issue(1'b1, 10'h003, 8'h77, 8'h00);
        req = 1'b0;
        @(posedge clk); #1;
        check(write_m, "write_strobe_up", write_m, 1);
        reset = 1'b1;
        exp_q.delete();
        last_rd[0] = '0;
        last_rd[1] = '0;
        #1;
        check(!write_m && !read_m, "reset_drops_strobes", {read_m, write_m}, 0);
        check(!oe_m, "reset_releases_bus", oe_m, 0);
        check(!done_m, "reset_no_done", done_m, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check(ready_m, "ready_after_abort", ready_m, 1);
        @(posedge clk); #1;

        // Write 0x05 to address 1
        issue(1'b1, 10'h001, 8'h05, 8'h00);
        drain();
        check(ram0[1] == 8'h05, "ram1_write", ram0[1], 8'h05);

        // Write 0x0A to address 2, then read address 1
        issue(1'b1, 10'h002, 8'h0A, 8'h00);
        drain();
        issue(1'b0, 10'h001, 8'h00, 8'h05);
        drain();

        // Back-to-back read then write with req held high
        issue(1'b0, 10'h002, 8'h00, 8'h0A);
        issue(1'b1, 10'h002, 8'hFF, 8'h00);
        drain();
        check(ram0[2] == 8'hFF, "ram2_overwrite", ram0[2], 8'hFF);

        // Request pulsed during the read strobe must be ignored
        watch_3ff = 1'b1;
        issue(1'b0, 10'h001, 8'h00, 8'h05);
        req = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; addr = 10'h3FF; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        watch_3ff = 1'b0;
        check(exp_q.size() == 0, "no_extra_txn", exp_q.size(), 0);

        // Longer strobes, top address round trip
        sel = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 10'h3FF, 8'hC3, 8'h00);
        drain();
        check(ram1[1023] == 8'hC3, "ram_top_write", ram1[1023], 8'hC3);
        issue(1'b0, 10'h3FF, 8'h00, 8'hC3);
        drain();
        check(rdata_m == 8'hC3, "rdata_held", rdata_m, 8'hC3);

        repeat (3) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
